// File: rtl/ahb_sram_slv_if.sv
// AHB-Lite bus bundle between a master (DMA port or bench) and the SRAM slave.
interface ahb_sram_slv_if;
   logic        HSEL;
   logic        HREADYIN;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HREADYIN, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HREADYIN, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_sram_slv.sv
// AHB-Lite SRAM slave: byte/half/word access, fixed wait states, two-cycle ERROR
// response for oversize, misaligned or out-of-range transfers.
module ahb_sram_slv #(
   parameter int MEM_WORDS   = 256,
   parameter int AW          = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          HCLK,
   input  logic          HRESET,
   ahb_sram_slv_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LAST,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [AW-1:0] addr_q;
   logic [3:0]  mask_q;
   logic        write_q;

   logic        accept;
   logic        legal;
   logic        load;
   logic [3:0]  mask_d;

   logic [31:0] mem [MEM_WORDS];

   // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike.
   logic unused_htrans0;
   assign unused_htrans0 = bus.HTRANS[0];

   assign accept = bus.HSEL & bus.HREADYIN & bus.HTRANS[1];

   always_comb begin
      legal = 1'b1;
      if (bus.HSIZE > 3'b010)
         legal = 1'b0;
      if (bus.HSIZE == 3'b001 && bus.HADDR[0])
         legal = 1'b0;
      if (bus.HSIZE == 3'b010 && bus.HADDR[1:0] != 2'b00)
         legal = 1'b0;
      if (bus.HADDR[31:2] >= 30'(MEM_WORDS))
         legal = 1'b0;
   end

   // Little-endian lane mask; it fully encodes the transfer size for the data phase.
   always_comb begin
      mask_d = 4'b0000;
      case (bus.HSIZE)
         3'b000:  mask_d = 4'b0001 << bus.HADDR[1:0];
         3'b001:  mask_d = 4'b0011 << {bus.HADDR[1], 1'b0};
         3'b010:  mask_d = 4'b1111;
         default: mask_d = 4'b0000;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         mask_q  <= 4'b0000;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load) begin
            addr_q  <= bus.HADDR[AW+1:2];
            mask_q  <= mask_d;
            write_q <= bus.HWRITE;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      load          = 1'b0;
      bus.HREADYOUT = 1'b1;
      bus.HRESP     = 1'b0;
      bus.HRDATA    = 32'h0;
      case (state_q)
         S_WAIT: begin
            bus.HREADYOUT = 1'b0;
            cnt_d         = cnt_q - 4'd1;
            if (cnt_q <= 4'd1)
               state_d = S_LAST;
         end
         S_ERR1: begin
            bus.HREADYOUT = 1'b0;
            bus.HRESP     = 1'b1;
            state_d       = S_ERR2;
         end
         default: begin
            // IDLE, LAST and ERR2 all drive HREADYOUT high, so a new address
            // phase can be taken here back-to-back.
            if (state_q == S_ERR2)
               bus.HRESP = 1'b1;
            if (state_q == S_LAST && !write_q)
               bus.HRDATA = mem[addr_q];
            state_d = S_IDLE;
            if (accept) begin
               load = 1'b1;
               if (!legal) begin
                  state_d = S_ERR1;
               end else if (WAIT_CYCLES == 0) begin
                  state_d = S_LAST;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES);
               end
            end
         end
      endcase
   end

   // Commit on the edge that closes LAST; a following read sees the new word.
   always_ff @(posedge HCLK) begin
      if (!HRESET && state_q == S_LAST && write_q) begin
         for (int b = 0; b < 4; b++)
            if (mask_q[b])
               mem[addr_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_ahb_sram_slv.sv
// Directed bench: three slaves (0, 1, 3 wait states) on private buses, one master.
module tb_ahb_sram_slv;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        hsel;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hrdy_en;
   int          tgt;

   logic [2:0]  rdy;
   logic [2:0]  resp;
   logic [31:0] rdata [3];

   int total = 0;
   int bad   = 0;

   always #5 HCLK = ~HCLK;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      ahb_sram_slv_if bi ();
      assign bi.HSEL     = hsel && (tgt == k);
      assign bi.HREADYIN = hrdy_en & bi.HREADYOUT;
      assign bi.HTRANS   = htrans;
      assign bi.HSIZE    = hsize;
      assign bi.HWRITE   = hwrite;
      assign bi.HADDR    = haddr;
      assign bi.HWDATA   = hwdata;
      assign rdy[k]      = bi.HREADYOUT;
      assign resp[k]     = bi.HRESP;
      assign rdata[k]    = bi.HRDATA;

      ahb_sram_slv #(
         .MEM_WORDS  (256),
         .AW         (8),
         .WAIT_CYCLES((k == 0) ? 0 : (k == 1) ? 1 : 3)
      ) u_dut (
         .HCLK  (HCLK),
         .HRESET(HRESET),
         .bus   (bi.slave)
      );
   end

   typedef struct {
      string       name;
      int          dut;
      logic        wr;
      logic [2:0]  sz;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          exp_w;
      logic        exp_err;
      logic        chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(string nm, int d, logic w, logic [2:0] s, logic [31:0] a,
                               logic [31:0] wd, int ew, logic ee, logic cr, logic [31:0] er);
      vec_t v;
      v.name = nm; v.dut = d; v.wr = w; v.sz = s; v.addr = a; v.wdata = wd;
      v.exp_w = ew; v.exp_err = ee; v.chk_rd = cr; v.exp_rd = er;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic idle_bus();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; haddr = 32'h0;
   endtask

   // One isolated transfer; reports data-phase stall count, stall-time HRESP,
   // completion HRESP and completion HRDATA.
   task automatic xfer(input int d, input logic w, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] wd, output int waits, output logic resp_low,
                       output logic resp_fin, output logic [31:0] rd, output logic tmo);
      waits = 0; resp_low = 1'b0; resp_fin = 1'b0; rd = 32'h0; tmo = 1'b1;
      @(posedge HCLK); #1;
      tgt = d; hsel = 1'b1; htrans = 2'b10; hwrite = w; hsize = s; haddr = a;
      @(posedge HCLK); #1;
      idle_bus();
      hwdata = wd;
      for (int c = 0; c < 20; c++) begin
         @(negedge HCLK);
         if (rdy[d]) begin
            resp_fin = resp[d];
            rd       = rdata[d];
            tmo      = 1'b0;
            break;
         end
         waits++;
         resp_low = resp_low | resp[d];
      end
   endtask

   initial begin
      int          w;
      logic        rl, rf, to;
      logic [31:0] rd;

      tbl[0]  = mk("wr_10",      1, 1, 3'b010, 32'h10,  32'hDEADBEEF, 1, 0, 0, 32'h0);
      tbl[1]  = mk("rd_10",      1, 0, 3'b010, 32'h10,  32'h0,        1, 0, 1, 32'hDEADBEEF);
      tbl[2]  = mk("wr_20",      1, 1, 3'b010, 32'h20,  32'h11223344, 1, 0, 0, 32'h0);
      tbl[3]  = mk("wrb_22",     1, 1, 3'b000, 32'h22,  32'h00AA0000, 1, 0, 0, 32'h0);
      tbl[4]  = mk("wrh_20",     1, 1, 3'b001, 32'h20,  32'h0000BBCC, 1, 0, 0, 32'h0);
      tbl[5]  = mk("rd_20",      1, 0, 3'b010, 32'h20,  32'h0,        1, 0, 1, 32'h11AABBCC);
      tbl[6]  = mk("rdb_23",     1, 0, 3'b000, 32'h23,  32'h0,        1, 0, 1, 32'h11AABBCC);
      tbl[7]  = mk("wr_30",      1, 1, 3'b010, 32'h30,  32'hCAFEF00D, 1, 0, 0, 32'h0);
      tbl[8]  = mk("err_wrh_31", 1, 1, 3'b001, 32'h31,  32'h12341234, 1, 1, 0, 32'h0);
      tbl[9]  = mk("err_rdw_02", 1, 0, 3'b010, 32'h02,  32'h0,        1, 1, 1, 32'h0);
      tbl[10] = mk("err_rdh_01", 1, 0, 3'b001, 32'h01,  32'h0,        1, 1, 1, 32'h0);
      tbl[11] = mk("err_sz3",    1, 0, 3'b011, 32'h00,  32'h0,        1, 1, 1, 32'h0);
      tbl[12] = mk("err_range",  1, 0, 3'b010, 32'h400, 32'h0,        1, 1, 1, 32'h0);
      tbl[13] = mk("rd_30",      1, 0, 3'b010, 32'h30,  32'h0,        1, 0, 1, 32'hCAFEF00D);
      tbl[14] = mk("w0_wr_44",   0, 1, 3'b010, 32'h44,  32'hA5A5A5A5, 0, 0, 0, 32'h0);
      tbl[15] = mk("w0_rd_44",   0, 0, 3'b010, 32'h44,  32'h0,        0, 0, 1, 32'hA5A5A5A5);
      tbl[16] = mk("w3_wr_50",   2, 1, 3'b010, 32'h50,  32'h55AA55AA, 3, 0, 0, 32'h0);
      tbl[17] = mk("w3_rd_50",   2, 0, 3'b010, 32'h50,  32'h0,        3, 0, 1, 32'h55AA55AA);

      HRESET = 1'b1; hrdy_en = 1'b1; tgt = 0; hwdata = 32'h0;
      idle_bus();
      repeat (3) @(posedge HCLK);
      #1 HRESET = 1'b0;
      @(negedge HCLK);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_rdy%0d", k),   32'(rdy[k]),  32'h1);
         chk($sformatf("rst_resp%0d", k),  32'(resp[k]), 32'h0);
         chk($sformatf("rst_rdata%0d", k), rdata[k],     32'h0);
      end

      for (int i = 0; i < 18; i++) begin
         xfer(tbl[i].dut, tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].wdata, w, rl, rf, rd, to);
         chk({tbl[i].name, "_tmo"},  32'(to), 32'h0);
         chk({tbl[i].name, "_wait"}, 32'(w),  32'(tbl[i].exp_w));
         chk({tbl[i].name, "_rlow"}, 32'(rl), 32'(tbl[i].exp_err));
         chk({tbl[i].name, "_resp"}, 32'(rf), 32'(tbl[i].exp_err));
         if (tbl[i].chk_rd)
            chk({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rd);
      end

      // Zero-wait pipelined write then read of the same word.
      @(posedge HCLK); #1;
      tgt = 0; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h40;
      @(posedge HCLK); #1;
      hwrite = 1'b0; hwdata = 32'h5;
      @(negedge HCLK);
      chk("b2b_wr_rdy",  32'(rdy[0]),  32'h1);
      chk("b2b_wr_resp", 32'(resp[0]), 32'h0);
      @(posedge HCLK); #1;
      idle_bus();
      @(negedge HCLK);
      chk("b2b_rd_rdy",  32'(rdy[0]), 32'h1);
      chk("b2b_rd_data", rdata[0],    32'h00000005);

      // IDLE and BUSY with HSEL, then NONSEQ while another slave stalls.
      @(posedge HCLK); #1;
      tgt = 1; hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = 32'h10; hwdata = 32'h0;
      @(posedge HCLK); #1;
      htrans = 2'b01;
      @(negedge HCLK);
      chk("idle_rdy",  32'(rdy[1]),  32'h1);
      chk("idle_resp", 32'(resp[1]), 32'h0);
      @(posedge HCLK); #1;
      htrans = 2'b10; hrdy_en = 1'b0;
      @(negedge HCLK);
      chk("busy_rdy",  32'(rdy[1]),  32'h1);
      chk("busy_resp", 32'(resp[1]), 32'h0);
      @(posedge HCLK); #1;
      idle_bus(); hrdy_en = 1'b1;
      @(negedge HCLK);
      chk("nrdy_rdy",  32'(rdy[1]),  32'h1);
      chk("nrdy_resp", 32'(resp[1]), 32'h0);
      xfer(1, 1'b0, 3'b010, 32'h10, 32'h0, w, rl, rf, rd, to);
      chk("nowr_rdata", rd, 32'hDEADBEEF);

      // Reset during the wait states of a write drops it.
      @(posedge HCLK); #1;
      tgt = 2; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h50;
      @(posedge HCLK); #1;
      idle_bus(); hwdata = 32'hFFFFFFFF;
      @(negedge HCLK);
      chk("rstw_wait", 32'(rdy[2]), 32'h0);
      @(posedge HCLK); #1;
      HRESET = 1'b1;
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      @(negedge HCLK);
      chk("rstw_rdy",   32'(rdy[2]),  32'h1);
      chk("rstw_resp",  32'(resp[2]), 32'h0);
      chk("rstw_rdata", rdata[2],     32'h0);
      xfer(2, 1'b0, 3'b010, 32'h50, 32'h0, w, rl, rf, rd, to);
      chk("rstw_keep", rd, 32'h55AA55AA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
